// File: rtl/seq_divider_8by4.sv
// Sequential 8-bit by 4-bit unsigned restoring divider: accepts one operand pair
// while ready, produces one quotient bit per cycle MSB first, and pulses done.
module seq_divider_8by4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       ready,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [4:0] prem_q, prem_d;
  logic [7:0] quo_q, quo_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quotient_q, quotient_d;
  logic [3:0] remainder_q, remainder_d;
  logic       dbz_q, dbz_d;

  logic [5:0] shifted;
  logic [5:0] trial;
  logic       q_bit;
  logic [4:0] next_prem;

  // One restoring step: the partial remainder stays below the divisor, so the
  // extra top bit of the shifted value is always zero and trial[5] is a clean sign.
  always_comb begin
    shifted   = {prem_q, dvd_q[7]};
    trial     = shifted - {2'b00, dvs_q};
    q_bit     = ~trial[5];
    next_prem = q_bit ? trial[4:0] : shifted[4:0];
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          prem_d = 5'd0;
          quo_d  = 8'd0;
          if (divisor == 4'd0) begin
            quotient_d  = 8'hFF;
            remainder_d = 4'h0;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d   = 3'd7;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prem_d = next_prem;
        dvd_d  = {dvd_q[6:0], 1'b0};
        quo_d  = {quo_q[6:0], q_bit};
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          quotient_d  = {quo_q[6:0], q_bit};
          remainder_d = next_prem[3:0];
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= 8'd0;
      dvs_q       <= 4'd0;
      prem_q      <= 5'd0;
      quo_q       <= 8'd0;
      cnt_q       <= 3'd0;
      quotient_q  <= 8'd0;
      remainder_q <= 4'd0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Directed and exhaustive bench for seq_divider_8by4; expected results come from
// a behavioural model pushed to a scoreboard at accept time and popped at done.
module tb_seq_divider_8by4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       ready;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_divider_8by4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF; e.r = 4'h0; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / {4'd0, b}; e.r = 4'(a % {4'd0, b}); e.dbz = 1'b0; e.lat = 9;
    end
    return e;
  endfunction

  // Called at a negedge; waits for ready, drives operands and start across one
  // accept edge, pushes the model's expectation and leaves start high if asked.
  task automatic do_start(input logic [7:0] a, input logic [3:0] b, input bit hold);
    int i;
    for (i = 0; i < 20; i++) begin
      if (ready === 1'b1) break;
      @(negedge clk);
    end
    if (i == 20) check("ready_timeout", 32'(ready), 32'd1);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    sb.push_back(model(a, b));
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts negedges after the accept edge until done, then compares against the
  // scoreboard head and checks the done pulse lasts one cycle.
  task automatic collect(input string tag);
    int   lat;
    exp_t e;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
    check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
    @(negedge clk);
    check({tag, "_done_pulse"}, {30'd0, done, ready}, 32'b01);
  endtask

  initial begin
    int dones;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_outputs", {19'd0, quotient, remainder, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_start(8'hC8, 4'h7, 1'b0);  collect("c8_7");
    do_start(8'hFF, 4'hF, 1'b0);  collect("ff_f");
    do_start(8'h0D, 4'hF, 1'b0);  collect("0d_f");
    do_start(8'h5A, 4'h0, 1'b0);  collect("div0");
    do_start(8'h09, 4'h3, 1'b0);  collect("09_3");

    // Start held and operands changed during CALC: exactly one result, from the latched pair.
    do_start(8'h64, 4'h9, 1'b1);
    @(negedge clk);
    dividend = 8'h10;
    divisor  = 4'h1;
    dones = 0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (ready === 1'b1 || done === 1'b1) dones++;
    end
    check("hold_busy_in_calc", 32'(dones), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("hold_done", 32'(done), 32'd1);
    check("hold_ready_low_at_done", 32'(ready), 32'd0);
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("hold_quotient", 32'(quotient), 32'(e.q));
      check("hold_remainder", 32'(remainder), 32'(e.r));
    end
    @(negedge clk);
    check("hold_single_done", {30'd0, done, ready}, 32'b01);
    check("hold_quotient_held", 32'(quotient), 32'h0B);

    // Reset in the fourth CALC cycle aborts the operation with no done.
    do_start(8'hC8, 4'h7, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_ready", 32'(ready), 32'd1);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_outputs", {19'd0, quotient, remainder, div_by_zero}, 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("midreset_no_done", 32'(dones), 32'd0);
    do_start(8'h64, 4'h9, 1'b0);  collect("after_reset");

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_start(8'(a), 4'(b), 1'b0);
        collect("sweep");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
